epc_tracker: RTL

EPC_TRACKER -- requirements
Module: epc_tracker

---
 rtl/epc_tracker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/epc_tracker.sv
// epc_tracker: tracks the PC of the current stage instruction, a short
// history of captured PCs and the exception PC latched on exception entry.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   reset        - asynchronous active-low reset
//   in_valid     - a stage instruction is present
//   in_pc        - PC of the stage instruction (AW bits)
//   in_bd        - stage instruction sits in a branch delay slot
//   stall        - freezes capture and history
//   flush        - stage content this cycle is discarded
//   exc_req      - exception-entry pulse
//   exc_ack      - exception-return pulse (eret)
//   hist_idx     - history read index, 0 is newest
//   cur_pc       - last captured PC
//   cur_bd       - BD flag of cur_pc
//   cur_valid    - at least one capture since reset
//   epc          - latched exception PC
//   epc_bd       - latched BD flag
//   exc_pending  - exception entered and not yet acknowledged
//   hist_pc      - history entry selected by hist_idx (0 when out of range)
//   hist_count   - number of valid history entries
module epc_tracker #(
    parameter int AW          = 32,
    parameter int DEPTH       = 4,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [AW-1:0]              in_pc,
    input  logic                       in_bd,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       exc_req,
    input  logic                       exc_ack,
    input  logic [$clog2(DEPTH)-1:0]   hist_idx,
    output logic [AW-1:0]              cur_pc,
    output logic                       cur_bd,
    output logic                       cur_valid,
    output logic [AW-1:0]              epc,
    output logic                       epc_bd,
    output logic                       exc_pending,
    output logic [AW-1:0]              hist_pc,
    output logic [$clog2(DEPTH):0]     hist_count
);

    localparam int            IW   = $clog2(DEPTH);
    localparam logic [IW:0]   FULL = (IW+1)'(DEPTH);

    logic          bubble;
    logic          capture;
    logic [AW-1:0] src_pc;
    logic          src_bd;
    logic [AW-1:0] exc_pc;
    logic          take_exc;

    logic [AW-1:0] hist_mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_ptr;

    // A zero PC is treated as a pipeline bubble only when enabled.
    always_comb begin
        bubble  = ZERO_BUBBLE && (in_pc == '0);
        capture = in_valid && !stall && !flush && !bubble;
    end

    // The exception source follows the instruction being captured this
    // cycle so a same-cycle exception sees the newest PC.
    always_comb begin
        if (capture) begin
            src_pc = in_pc;
            src_bd = in_bd;
        end else begin
            src_pc = cur_pc;
            src_bd = cur_bd;
        end
    end

    // A delay-slot instruction restarts at its branch, one word earlier.
    always_comb begin
        exc_pc   = src_bd ? (src_pc - AW'(4)) : src_pc;
        take_exc = exc_req && !exc_pending;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_pc    <= '0;
            cur_bd    <= 1'b0;
            cur_valid <= 1'b0;
        end else if (capture) begin
            cur_pc    <= in_pc;
            cur_bd    <= in_bd;
            cur_valid <= 1'b1;
        end
    end

    // Ack wins over a simultaneous request; a request while pending is
    // dropped so the first exception PC is preserved.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc         <= '0;
            epc_bd      <= 1'b0;
            exc_pending <= 1'b0;
        end else if (exc_pending) begin
            if (exc_ack) begin
                exc_pending <= 1'b0;
            end
        end else if (take_exc) begin
            epc         <= exc_pc;
            epc_bd      <= src_bd;
            exc_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            hist_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_mem[i] <= '0;
            end
        end else if (capture) begin
            hist_mem[wr_ptr] <= in_pc;
            wr_ptr           <= wr_ptr + IW'(1);
            if (hist_count != FULL) begin
                hist_count <= hist_count + (IW+1)'(1);
            end
        end
    end

    // wr_ptr points at the next free slot; newest is one behind it.
    // DEPTH is a power of two so the subtraction wraps naturally.
    always_comb begin
        rd_ptr  = wr_ptr - IW'(1) - hist_idx;
        hist_pc = '0;
        if ({1'b0, hist_idx} < hist_count) begin
            hist_pc = hist_mem[rd_ptr];
        end
    end

endmodule
